// File: rtl/thongke_sosanh.sv
// thongke_sosanh: per-frame statistics of comparator results {lt,eq,gt}.
// Ports: clk, rst_n (sync, active-low), start, v, y[2:0] -> busy, done,
//   n_lt/n_eq/n_gt/run_gt [CW-1:0] (saturating), err (sticky per frame).
module thongke_sosanh #(
  parameter int N  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          v,
  input  logic [2:0]    y,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] n_lt,
  output logic [CW-1:0] n_eq,
  output logic [CW-1:0] n_gt,
  output logic [CW-1:0] run_gt,
  output logic          err
);

  localparam int SW = $clog2(N + 1);
  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [CW-1:0] MAXV = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [CW-1:0] lt_q, lt_d;
  logic [CW-1:0] eq_q, eq_d;
  logic [CW-1:0] gt_q, gt_d;
  logic [CW-1:0] rmax_q, rmax_d;
  logic          err_q, err_d;
  logic [CW-1:0] cur_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a);
    return (a == MAXV) ? a : a + CW'(1);
  endfunction

  assign cur_inc = sat_inc(cur_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    rmax_d  = rmax_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          cur_d   = '0;
          lt_d    = '0;
          eq_d    = '0;
          gt_d    = '0;
          rmax_d  = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (v) begin
          cnt_d = cnt_q + SW'(1);
          unique case (y)
            3'b100: begin
              lt_d  = sat_inc(lt_q);
              cur_d = '0;
            end
            3'b010: begin
              eq_d  = sat_inc(eq_q);
              cur_d = '0;
            end
            3'b001: begin
              gt_d  = sat_inc(gt_q);
              cur_d = cur_inc;
              if (cur_inc > rmax_q) rmax_d = cur_inc;
            end
            default: begin
              err_d = 1'b1;
              cur_d = '0;
            end
          endcase
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      gt_q    <= '0;
      rmax_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      rmax_q  <= rmax_d;
      err_q   <= err_d;
    end
  end

  // Status flags are pure decodes of the state register.
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign n_lt   = lt_q;
  assign n_eq   = eq_q;
  assign n_gt   = gt_q;
  assign run_gt = rmax_q;
  assign err    = err_q;

endmodule

// File: tb/tb_thongke_sosanh.sv
// tb_thongke_sosanh: directed tests for thongke_sosanh.
// Three instances: N=4/CW=8, N=6/CW=3, N=6/CW=2.
module tb_thongke_sosanh;

  logic clk = 1'b0;
  logic rst_n, v;
  logic [2:0] y;
  logic s4, s3, s2;

  logic b4, d4, e4;
  logic [7:0] lt4, eq4, gt4, rg4;
  logic b3, d3, e3;
  logic [2:0] lt3, eq3, gt3, rg3;
  logic b2, d2, e2;
  logic [1:0] lt2, eq2, gt2, rg2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  thongke_sosanh #(.N(4), .CW(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .v(v), .y(y),
    .busy(b4), .done(d4), .n_lt(lt4), .n_eq(eq4),
    .n_gt(gt4), .run_gt(rg4), .err(e4)
  );

  thongke_sosanh #(.N(6), .CW(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .v(v), .y(y),
    .busy(b3), .done(d3), .n_lt(lt3), .n_eq(eq3),
    .n_gt(gt3), .run_gt(rg3), .err(e3)
  );

  thongke_sosanh #(.N(6), .CW(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .v(v), .y(y),
    .busy(b2), .done(d2), .n_lt(lt2), .n_eq(eq2),
    .n_gt(gt2), .run_gt(rg2), .err(e2)
  );

  // {busy,done,n_lt,n_eq,n_gt,run_gt,err} of the N=4 instance
  logic [34:0] o4;
  assign o4 = {b4, d4, lt4, eq4, gt4, rg4, e4};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start4;
    s4 = 1'b1;
    tick();
    s4 = 1'b0;
    checks++;
    if ({b4, d4} !== 2'b10) begin
      errors++;
      $display("FAIL start_busy got=%b want=10", {b4, d4});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s4 = 1'b1; s3 = 1'b1; s2 = 1'b1;
    v = 1'b1; y = 3'b001;
    tick();
    tick();
    checks++;
    if (o4 !== 35'd0) begin
      errors++;
      $display("FAIL reset_n4 got=%h want=0", o4);
    end
    checks++;
    if ({b3, d3, lt3, eq3, gt3, rg3, e3} !== 15'd0) begin
      errors++;
      $display("FAIL reset_n6c3 got=%h want=0",
               {b3, d3, lt3, eq3, gt3, rg3, e3});
    end
    checks++;
    if ({b2, d2, lt2, eq2, gt2, rg2, e2} !== 11'd0) begin
      errors++;
      $display("FAIL reset_n6c2 got=%h want=0",
               {b2, d2, lt2, eq2, gt2, rg2, e2});
    end
    s4 = 1'b0; s3 = 1'b0; s2 = 1'b0;
    v = 1'b0; y = 3'b000;
    rst_n = 1'b1;
    tick();
    checks++;
    if (o4 !== 35'd0) begin
      errors++;
      $display("FAIL reset_idle got=%h want=0", o4);
    end
  endtask

  task automatic test_basic;
    logic [2:0] seq [4];
    seq = '{3'b100, 3'b010, 3'b001, 3'b001};
    // valid gt sample in the start cycle must not count
    v = 1'b1; y = 3'b001;
    start4();
    for (int i = 0; i < 4; i++) begin
      y = seq[i];
      tick();
      if (i < 3) begin
        checks++;
        if ({b4, d4} !== 2'b10) begin
          errors++;
          $display("FAIL basic_run%0d got=%b want=10", i, {b4, d4});
        end
      end
    end
    v = 1'b0; y = 3'b000;
    checks++;
    if (o4 !== {2'b01, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL basic_done got=%h want=%h", o4,
               {2'b01, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0});
    end
    tick();
    checks++;
    if (o4 !== {2'b00, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL basic_hold got=%h want=%h", o4,
               {2'b00, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0});
    end
    tick();
    checks++;
    if (o4 !== {2'b00, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL basic_hold2 got=%h want=%h", o4,
               {2'b00, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0});
    end
  endtask

  task automatic test_gaps;
    logic [3:0] vs [7];
    int cyc;
    // {v, y} per cycle
    vs = '{4'b1001, 4'b0001, 4'b0001, 4'b0001,
           4'b1001, 4'b1001, 4'b1010};
    start4();
    cyc = 0;
    for (int i = 0; i < 7; i++) begin
      {v, y} = vs[i];
      tick();
      cyc++;
      if (i < 6) begin
        checks++;
        if (d4 !== 1'b0) begin
          errors++;
          $display("FAIL gaps_early cyc=%0d done=%b want=0", cyc, d4);
        end
      end
    end
    v = 1'b0; y = 3'b000;
    checks++;
    if (o4 !== {2'b01, 8'd0, 8'd1, 8'd3, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL gaps_done got=%h want=%h", o4,
               {2'b01, 8'd0, 8'd1, 8'd3, 8'd3, 1'b0});
    end
    tick();
  endtask

  task automatic test_malformed;
    logic [2:0] seq [4];
    seq = '{3'b001, 3'b000, 3'b001, 3'b011};
    start4();
    v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y = seq[i];
      tick();
    end
    v = 1'b0; y = 3'b000;
    checks++;
    if (o4 !== {2'b01, 8'd0, 8'd0, 8'd2, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL malformed got=%h want=%h", o4,
               {2'b01, 8'd0, 8'd0, 8'd2, 8'd1, 1'b1});
    end
    tick();
  endtask

  task automatic test_midframe_reset;
    start4();
    v = 1'b1; y = 3'b001;
    tick();
    y = 3'b010;
    tick();
    v = 1'b0;
    s4 = 1'b1;
    tick();
    s4 = 1'b0;
    checks++;
    if (o4 !== {2'b10, 8'd0, 8'd1, 8'd1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL mid_start_ignored got=%h want=%h", o4,
               {2'b10, 8'd0, 8'd1, 8'd1, 8'd1, 1'b0});
    end
    rst_n = 1'b0;
    v = 1'b1; y = 3'b001;
    tick();
    rst_n = 1'b1;
    checks++;
    if (o4 !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset got=%h want=0", o4);
    end
    // two more valid samples would finish the old frame if it survived
    tick();
    tick();
    v = 1'b0;
    tick();
    checks++;
    if (o4 !== 35'd0) begin
      errors++;
      $display("FAIL mid_no_done got=%h want=0", o4);
    end
    start4();
    v = 1'b1;
    y = 3'b100; tick();
    y = 3'b100; tick();
    y = 3'b100; tick();
    y = 3'b010; tick();
    v = 1'b0; y = 3'b000;
    checks++;
    if (o4 !== {2'b01, 8'd3, 8'd1, 8'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_clean got=%h want=%h", o4,
               {2'b01, 8'd3, 8'd1, 8'd0, 8'd0, 1'b0});
    end
    tick();
  endtask

  task automatic test_back_to_back;
    // frame ends at tk, IDLE from tk+1, start asserted right away
    start4();
    v = 1'b1; y = 3'b001;
    for (int i = 0; i < 4; i++) tick();
    v = 1'b0;
    checks++;
    if (o4 !== {2'b01, 8'd0, 8'd0, 8'd4, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first got=%h want=%h", o4,
               {2'b01, 8'd0, 8'd0, 8'd4, 8'd4, 1'b0});
    end
    tick();
    start4();
    checks++;
    if (o4 !== {2'b10, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_cleared got=%h want=%h", o4,
               {2'b10, 32'd0, 1'b0});
    end
    v = 1'b1;
    y = 3'b001; tick();
    y = 3'b001; tick();
    y = 3'b100; tick();
    y = 3'b001; tick();
    v = 1'b0;
    checks++;
    if (o4 !== {2'b01, 8'd1, 8'd0, 8'd3, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got=%h want=%h", o4,
               {2'b01, 8'd1, 8'd0, 8'd3, 8'd2, 1'b0});
    end
    tick();
  endtask

  task automatic test_saturation;
    s3 = 1'b1; s2 = 1'b1;
    tick();
    s3 = 1'b0; s2 = 1'b0;
    v = 1'b1; y = 3'b001;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 4) begin
        checks++;
        if ({d3, d2, b3, b2} !== 4'b0011) begin
          errors++;
          $display("FAIL sat_early got=%b want=0011", {d3, d2, b3, b2});
        end
      end
    end
    v = 1'b0; y = 3'b000;
    checks++;
    if ({b3, d3, lt3, eq3, gt3, rg3, e3} !==
        {2'b01, 3'd0, 3'd0, 3'd6, 3'd6, 1'b0}) begin
      errors++;
      $display("FAIL sat_cw3 got=%h want=%h",
               {b3, d3, lt3, eq3, gt3, rg3, e3},
               {2'b01, 3'd0, 3'd0, 3'd6, 3'd6, 1'b0});
    end
    checks++;
    if ({b2, d2, lt2, eq2, gt2, rg2, e2} !==
        {2'b01, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL sat_cw2 got=%h want=%h",
               {b2, d2, lt2, eq2, gt2, rg2, e2},
               {2'b01, 2'd0, 2'd0, 2'd3, 2'd3, 1'b0});
    end
    checks++;
    if (o4 !== {2'b00, 8'd1, 8'd0, 8'd3, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL sat_n4_idle got=%h want=%h", o4,
               {2'b00, 8'd1, 8'd0, 8'd3, 8'd2, 1'b0});
    end
    tick();
    checks++;
    if ({d3, d2, gt3, gt2} !== {2'b00, 3'd6, 2'd3}) begin
      errors++;
      $display("FAIL sat_hold got=%h want=%h",
               {d3, d2, gt3, gt2}, {2'b00, 3'd6, 2'd3});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s4 = 1'b0; s3 = 1'b0; s2 = 1'b0;
    v = 1'b0; y = 3'b000;
    test_reset();
    test_basic();
    test_gaps();
    test_malformed();
    test_midframe_reset();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
